// File: rtl/mopa_exec_unit_pkg.sv
// Shared ALU control codes and MOPA execute-unit FSM state encodings.
package mopa_exec_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'h0,
    AluSub  = 4'h1,
    AluAnd  = 4'h2,
    AluOr   = 4'h3,
    AluXor  = 4'h4,
    AluSll  = 4'h5,
    AluSrl  = 4'h6,
    AluSra  = 4'h7,
    AluSlt  = 4'h8,
    AluSltu = 4'h9,
    AluMopa = 4'hA
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MopaIdle = 2'd0,
    MopaRun  = 2'd1,
    MopaDone = 2'd2
  } mopa_state_e;

endpackage

// File: rtl/mopa_row_mac.sv
// One accumulator row update: sum[j] = acc[j] + sext(a * b[j]) for all columns.
module mopa_row_mac #(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 8,
  parameter int unsigned AW = 32
) (
  input  logic [EW-1:0]   a_elem_i,
  input  logic [N*EW-1:0] b_vec_i,
  input  logic [N*AW-1:0] acc_row_i,
  output logic [N*AW-1:0] sum_row_o
);

  for (genvar j = 0; j < N; j++) begin : g_col
    logic signed [2*EW-1:0] prod;
    assign prod = $signed(a_elem_i) * $signed(b_vec_i[j*EW +: EW]);
    // Size cast of a signed value sign-extends; the add wraps modulo 2^AW.
    assign sum_row_o[j*AW +: AW] = acc_row_i[j*AW +: AW] + AW'(prod);
  end

endmodule

// File: rtl/mopa_exec_unit.sv
// Multi-cycle outer-product accumulate unit: one tile row per cycle, stalls while busy.
module mopa_exec_unit
  import mopa_exec_unit_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 8,
  parameter int unsigned AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [3:0]           alu_ctrl_i,
  input  logic [N*EW-1:0]      a_vec_i,
  input  logic [N*EW-1:0]      b_vec_i,
  input  logic                 clr_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic                 rd_en_i,
  input  logic [$clog2(N)-1:0] rd_row_i,
  output logic [N*AW-1:0]      rd_data_o
);

  localparam int unsigned RW = $clog2(N);

  mopa_state_e   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [N*EW-1:0] a_q, a_d, b_q, b_d;
  logic [N*AW-1:0] acc_q [N];
  logic [N*AW-1:0] acc_d [N];
  logic [N*AW-1:0] rd_data_q, rd_data_d;
  logic            err_q, err_d;
  logic [EW-1:0]   a_elem;
  logic [N*AW-1:0] mac_row;

  assign a_elem = a_q[row_q*EW +: EW];

  mopa_row_mac #(
    .N  (N),
    .EW (EW),
    .AW (AW)
  ) u_row_mac (
    .a_elem_i  (a_elem),
    .b_vec_i   (b_q),
    .acc_row_i (acc_q[row_q]),
    .sum_row_o (mac_row)
  );

  // FSM next state, operand latch and row counter.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    unique case (state_q)
      MopaIdle: begin
        if (valid_i) begin
          if (alu_ctrl_i == AluMopa) begin
            state_d = MopaRun;
            row_d   = '0;
            a_d     = a_vec_i;
            b_d     = b_vec_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MopaRun: begin
        row_d = row_q + 1'b1;
        if (row_q == RW'(N - 1)) state_d = MopaDone;
      end
      MopaDone: state_d = MopaIdle;
      default:  state_d = MopaIdle;
    endcase
  end

  // Tile writeback: clear only from IDLE (ahead of any accumulate), one row per RUN cycle.
  always_comb begin
    for (int i = 0; i < N; i++) acc_d[i] = acc_q[i];
    if (state_q == MopaIdle && clr_i) begin
      for (int i = 0; i < N; i++) acc_d[i] = '0;
    end
    if (state_q == MopaRun) acc_d[row_q] = mac_row;
    // Reads see pre-edge tile contents.
    rd_data_d = rd_en_i ? acc_q[rd_row_i] : rd_data_q;
  end

  // State registers with synchronous reset; reset aborts any operation and zeroes the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MopaIdle;
      row_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      a_q       <= a_d;
      b_q       <= b_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign ready_o   = (state_q == MopaIdle);
  assign stall_o   = (state_q == MopaRun);
  assign done_o    = (state_q == MopaDone);
  assign err_o     = err_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mopa_exec_unit.sv
// Self-checking bench for mopa_exec_unit against an arithmetic tile model.
module tb_mopa_exec_unit;
  import mopa_exec_unit_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      alu_ctrl_i;
  logic [N*EW-1:0] a_vec_i;
  logic [N*EW-1:0] b_vec_i;
  logic            clr_i;
  logic            stall_o;
  logic            done_o;
  logic            err_o;
  logic            rd_en_i;
  logic [RW-1:0]   rd_row_i;
  logic [N*AW-1:0] rd_data_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] model [N][N];

  mopa_exec_unit #(
    .N  (N),
    .EW (EW),
    .AW (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .alu_ctrl_i (alu_ctrl_i),
    .a_vec_i    (a_vec_i),
    .b_vec_i    (b_vec_i),
    .clr_i      (clr_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_en_i    (rd_en_i),
    .rd_row_i   (rd_row_i),
    .rd_data_o  (rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int elem(input logic [N*EW-1:0] v, input int k);
    logic signed [EW-1:0] e;
    e = v[k*EW +: EW];
    return int'(e);
  endfunction

  function automatic logic [N*AW-1:0] model_row(input int r);
    logic [N*AW-1:0] row;
    for (int j = 0; j < N; j++) row[j*AW +: AW] = model[r][j];
    return row;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) model[i][j] = '0;
  endtask

  task automatic model_mopa(input logic [N*EW-1:0] a, input logic [N*EW-1:0] b,
                            input logic clr);
    longint p;
    if (clr) model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        p = longint'(elem(a, i)) * longint'(elem(b, j));
        model[i][j] = model[i][j] + p[AW-1:0];
      end
  endtask

  task automatic read_row(input int r);
    rd_en_i  = 1'b1;
    rd_row_i = RW'(r);
    tick();
    rd_en_i  = 1'b0;
  endtask

  task automatic check_tile(input string tag);
    for (int r = 0; r < N; r++) begin
      read_row(r);
      chk($sformatf("%s_row%0d", tag, r), rd_data_o, model_row(r));
    end
  endtask

  // Issue one MOPA from IDLE and check the stall/done timeline; noisy keeps valid_i and
  // clr_i high and scrambles operands while the unit is busy.
  task automatic run_mopa(input logic [N*EW-1:0] a, input logic [N*EW-1:0] b,
                          input logic clr, input logic noisy);
    chk("idle_ready", ready_o, 1'b1);
    valid_i    = 1'b1;
    alu_ctrl_i = AluMopa;
    a_vec_i    = a;
    b_vec_i    = b;
    clr_i      = clr;
    tick();
    model_mopa(a, b, clr);
    valid_i = noisy;
    clr_i   = noisy;
    a_vec_i = $urandom;
    b_vec_i = $urandom;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("run%0d_stall", k), stall_o, 1'b1);
      chk($sformatf("run%0d_ready", k), ready_o, 1'b0);
      chk($sformatf("run%0d_done", k), done_o, 1'b0);
      tick();
      if (noisy) begin
        a_vec_i = $urandom;
        b_vec_i = $urandom;
      end
    end
    chk("done_pulse", done_o, 1'b1);
    chk("done_stall", stall_o, 1'b0);
    chk("done_ready", ready_o, 1'b0);
    valid_i = 1'b0;
    clr_i   = 1'b0;
    tick();
    chk("post_done", done_o, 1'b0);
    chk("post_ready", ready_o, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    valid_i    = 1'b0;
    alu_ctrl_i = AluAdd;
    a_vec_i    = '0;
    b_vec_i    = '0;
    clr_i      = 1'b0;
    rd_en_i    = 1'b0;
    rd_row_i   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rd", rd_data_o, '0);

    // a=[1,2,3,4], b=[1,1,1,1]
    run_mopa({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 1'b0, 1'b0);
    check_tile("first");

    // Same op without clear doubles everything
    run_mopa({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, 1'b0, 1'b0);
    check_tile("double");
    read_row(3);
    chk("double_row3_const", rd_data_o, {4{32'd8}});

    // Non-MOPA request: error pulse, tile untouched
    valid_i    = 1'b1;
    alu_ctrl_i = AluAdd;
    a_vec_i    = $urandom;
    b_vec_i    = $urandom;
    tick();
    valid_i = 1'b0;
    chk("err_pulse", err_o, 1'b1);
    chk("err_ready", ready_o, 1'b1);
    chk("err_stall", stall_o, 1'b0);
    tick();
    chk("err_clear", err_o, 1'b0);
    check_tile("after_err");

    // Clear in IDLE
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    model_clear();
    check_tile("clr");

    // Signed product: -128 * -128
    run_mopa({24'h0, 8'h80}, {24'h0, 8'h80}, 1'b1, 1'b0);
    read_row(0);
    chk("signed_16384", rd_data_o[AW-1:0], 32'd16384);
    check_tile("signed");

    // -1 * 1 on zero, then +1 wraps to zero
    run_mopa({24'h0, 8'hFF}, {24'h0, 8'h01}, 1'b1, 1'b0);
    read_row(0);
    chk("neg_one", rd_data_o[AW-1:0], 32'hFFFF_FFFF);
    run_mopa({24'h0, 8'h01}, {24'h0, 8'h01}, 1'b0, 1'b0);
    read_row(0);
    chk("wrap_zero", rd_data_o[AW-1:0], 32'h0);

    // Clear + MOPA together on a non-zero tile; busy-time valid/clr/operands ignored
    run_mopa({4{8'd3}}, {4{8'd5}}, 1'b0, 1'b0);
    run_mopa({4{8'd2}}, {4{8'd2}}, 1'b1, 1'b1);
    check_tile("clr_mopa");
    read_row(2);
    chk("clr_mopa_const", rd_data_o, {4{32'd4}});

    // Reset two cycles after accept aborts the operation
    valid_i    = 1'b1;
    alu_ctrl_i = AluMopa;
    a_vec_i    = $urandom;
    b_vec_i    = $urandom;
    tick();
    valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("abort_ready", ready_o, 1'b1);
    chk("abort_stall", stall_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_rd", rd_data_o, '0);
    for (int k = 0; k < N + 2; k++) begin
      tick();
      chk($sformatf("abort_nodone%0d", k), done_o, 1'b0);
    end
    check_tile("abort");

    // Random operations against the model
    for (int it = 0; it < 8; it++) begin
      logic [N*EW-1:0] ra, rb;
      logic rc, rn;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rn = 1'($urandom_range(0, 1));
      run_mopa(ra, rb, rc, rn);
      check_tile($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mopa_exec_unit.md
Name: mopa_exec_unit

Overview:
- Multi-cycle execute-stage unit downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code with two packed operand vectors.
- When the code is `MOPA, accumulates the outer product a*b^T into an internal NxN accumulator tile.
- Raises a stall to the pipeline while busy. A registered row-read port serves tile-to-register moves.

Parameters:
- N, 4, vector length and tile dimension (rows = columns = N); power of two, at least 2.
- EW, 8, element width in bits; elements are signed two's complement.
- AW, 32, accumulator element width in bits; AW >= 2*EW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  operation request from execute stage.
- ready_o  out  1  unit can accept a request this cycle.
- alu_ctrl_i  in  4  ALU control code; only `MOPA (from define.vh) starts work.
- a_vec_i  in  N*EW  column operand; element k is bits [k*EW +: EW].
- b_vec_i  in  N*EW  row operand; same packing as a_vec_i.
- clr_i  in  1  zero the whole accumulator tile.
- stall_o  out  1  pipeline freeze request while the unit is busy.
- done_o  out  1  one-cycle pulse when an accumulate completes.
- err_o  out  1  one-cycle pulse when a request carries a non-`MOPA code.
- rd_en_i  in  1  row read request.
- rd_row_i  in  log2(N)  row index to read.
- rd_data_o  out  N*AW  registered row data; column j is bits [j*AW +: AW].

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FSM goes to IDLE; all acc[i][j] clear to 0; row counter clears to 0.
  - Outputs after reset: ready_o=1, stall_o=0, done_o=0, err_o=0, rd_data_o=0.
  - Reset mid-operation aborts the operation: no done_o pulse, tile zeroed.
- FSM states IDLE, RUN, DONE:
  - IDLE: ready_o=1, stall_o=0. Accept when valid_i=1 and alu_ctrl_i==`MOPA. On accept, latch a_vec_i and b_vec_i, set row=0, go to RUN.
  - IDLE with valid_i=1 and any other code: no state change; err_o=1 on the next cycle; stay in IDLE.
  - RUN: ready_o=0, stall_o=1. Each cycle, for all j in 0..N-1: acc[row][j] <= acc[row][j] + sext(a[row]*b[j]). Then row increments. After the row=N-1 update, go to DONE.
  - DONE: ready_o=0, stall_o=0, done_o=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Accept edge at cycle t; rows update on edges t+1..t+N; done_o is high during cycle t+N+1.
  - Back-to-back issue is possible from cycle t+N+2.
- Arithmetic:
  - Product is a signed EW x EW multiply giving 2*EW bits, sign-extended to AW.
  - Accumulation wraps modulo 2^AW; there is no saturation or overflow flag.
- Input handling while busy:
  - valid_i is ignored in RUN and DONE; the requester holds it until ready_o=1.
  - Operands are used only from the latched copies, so input changes during RUN have no effect.
- Clear:
  - clr_i is honoured only in IDLE; it zeroes the tile at the next edge. It is ignored in RUN and DONE.
  - clr_i together with an accepted `MOPA in the same IDLE cycle: clear first, then accumulate from zero, so the result is exactly a*b^T.
- Read port:
  - rd_en_i=1 at an edge loads rd_data_o <= acc[rd_row_i] with the pre-edge contents; a same-edge update is not visible.
  - rd_data_o holds its value while rd_en_i=0. Reads are allowed in any state.

Decomposition:
- Shared define.vh package holds the existing `MOPA and the other ALU control codes, plus the FSM state encodings (MOPA_IDLE, MOPA_RUN, MOPA_DONE).
- One sub-module: mopa_row_mac. It takes the latched a[row], all N b elements and one accumulator row, and produces the N updated accumulator values combinationally.
- Instantiate mopa_row_mac once; the row mux and writeback stay in the parent.

Test Plan:
- Reset, then a=[1,2,3,4], b=[1,1,1,1], `MOPA -> done_o at accept+5; reading rows 0..3 returns each row filled with 1, 2, 3 and 4 respectively; stall_o high for exactly 4 cycles.
- Repeat the same op without clr_i -> every element doubles (row 3 = [8,8,8,8]). Then clr_i in IDLE -> every row reads 0.
- Signed/wrap check: a[0]=-128, b[0]=-128, AW=32 -> acc[0][0]=16384. Preload via repeated ops, then a=-1, b=1 on acc=0 -> 0xFFFFFFFF. Adding 1*1 then wraps it to 0.
- valid_i with alu_ctrl_i=`ADD in IDLE -> err_o pulses one cycle, ready_o stays 1, tile unchanged. valid_i held high during RUN -> no second accept until IDLE.
- Assert rst=1 two cycles after accepting a `MOPA -> next cycle ready_o=1, stall_o=0, no done_o pulse, all rows read 0.
- clr_i and a `MOPA with a=b=[2,2,2,2] in the same cycle on a non-zero tile -> all elements read 4. clr_i asserted during RUN -> ignored.
